// File: rtl/excess3_to_bcd_serial_pkg.sv
// Shared encoding for the serial Excess-3 to BCD converter.
// State = (bit position within the digit, borrow pending).
package excess3_to_bcd_serial_pkg;

  localparam int DIGIT_BITS = 4;

  typedef enum logic [2:0] {
    S0 = 3'd0,  // bit0, subtract 1
    S1 = 3'd1,  // bit1, no borrow
    S2 = 3'd2,  // bit1, borrow
    S3 = 3'd3,  // bit2, no borrow
    S4 = 3'd4,  // bit2, borrow
    S5 = 3'd5,  // bit3, no borrow
    S6 = 3'd6   // bit3, borrow
  } state_t;

endpackage

// File: rtl/excess3_to_bcd_serial.sv
// Bit-serial Excess-3 -> BCD converter (Mealy FSM, LSB first).
// Z = serial (X - 0011) with borrow; returns to S0 every DIGIT_BITS cycles.
module excess3_to_bcd_serial
  import excess3_to_bcd_serial_pkg::*;
(
  input  logic Clk,
  input  logic Rst,
  input  logic X,
  output logic Z
);

  state_t state_q, state_d;

  // State register; async reset parks the machine at bit0.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_q <= S0;
    else     state_q <= state_d;
  end

  // Next state and Mealy output from (state, X); Z held low during reset.
  always_comb begin
    state_d = S0;
    Z       = 1'b0;
    case (state_q)
      S0: begin Z = ~X;   state_d = X ? S1 : S2; end
      S1: begin Z = ~X;   state_d = X ? S3 : S4; end
      S2: begin Z = X;    state_d = S4;          end
      S3: begin Z = X;    state_d = S5;          end
      S4: begin Z = ~X;   state_d = X ? S5 : S6; end
      S5: begin Z = X;    state_d = S0;          end
      S6: begin Z = ~X;   state_d = S0;          end
      default: begin Z = 1'b0; state_d = S0;     end
    endcase
    if (Rst) Z = 1'b0;
  end

endmodule

// File: tb/tb_excess3_to_bcd_serial.sv
// Directed bench for excess3_to_bcd_serial with an expected-bit scoreboard.
module tb_excess3_to_bcd_serial;
  import excess3_to_bcd_serial_pkg::*;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  logic X   = 1'b0;
  logic Z;

  int checks = 0;
  int errors = 0;
  logic sb[$];

  excess3_to_bcd_serial dut (.Clk(Clk), .Rst(Rst), .X(X), .Z(Z));

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Push the expected BCD bits of one Excess-3 digit, LSB first.
  task automatic push_digit(input logic [3:0] e3);
    logic [3:0] bcd;
    bcd = e3 - 4'd3;
    for (int i = 0; i < DIGIT_BITS; i++) sb.push_back(bcd[i]);
  endtask

  // Called at posedge+1: drive one bit, check Z at the falling edge and
  // again just before the next rising edge, then return at posedge+1.
  task automatic send_bit(input logic b, input string tag);
    logic exp;
    X = b;
    @(negedge Clk);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 4'd1, 4'd0);
      exp = 1'bx;
    end else begin
      exp = sb.pop_front();
      chk(tag, {3'b0, Z}, {3'b0, exp});
    end
    #4;
    chk({tag, "_stable"}, {3'b0, Z}, {3'b0, exp});
    @(posedge Clk); #1;
  endtask

  task automatic send_digit(input logic [3:0] e3, input int nbits, input string tag);
    push_digit(e3);
    for (int i = 0; i < nbits; i++) send_bit(e3[i], tag);
  endtask

  // Assert reset `dly` after posedge+1 (mid-cycle, no clock edge), check
  // immediate effect, hold across one rising edge, release at posedge+1.
  task automatic pulse_reset(input int dly, input string tag);
    X = 1'b1;
    #(dly);
    Rst = 1'b1;
    #1;
    chk({tag, "_z"}, {3'b0, Z}, 4'd0);
    chk({tag, "_state"}, {1'b0, dut.state_q}, {1'b0, S0});
    sb.delete();
    @(posedge Clk); #1;
    chk({tag, "_hold"}, {1'b0, dut.state_q}, {1'b0, S0});
    Rst = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_z", {3'b0, Z}, 4'd0);
    chk("rst_state", {1'b0, dut.state_q}, {1'b0, S0});
    Rst = 1'b0;

    // Stream valid digits 3..12 back-to-back
    for (int v = 3; v <= 12; v++) send_digit(v[3:0], 4, "stream");

    // Reset after two bits of 0111, then 1000 -> 0101
    send_digit(4'b0111, 2, "partial");
    pulse_reset(0, "rst_mid");
    send_digit(4'b1000, 4, "after_rst");

    // Asynchronous reset asserted between clock edges, mid-digit
    send_digit(4'b1001, 2, "partial2");
    pulse_reset(2, "rst_async");
    send_digit(4'b1001, 4, "after_async");

    // Invalid codes keep word alignment
    send_digit(4'b0000, 4, "inv0000");
    send_digit(4'b1111, 4, "inv1111");
    send_digit(4'b0101, 4, "realign");

    // Exhaustive sweep
    for (int v = 0; v < 16; v++) send_digit(v[3:0], 4, "exh");

    chk("sb_drained", sb.size() == 0 ? 4'd1 : 4'd0, 4'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
